// File: rtl/if_id_buffer_if.sv
// IF/ID handshake bundle: fetch-side push, decode-side head/consume, flush and bubble counter.
interface if_id_buffer_if;
  logic [31:0] pc_if_i;
  logic [31:0] instr_if_i;
  logic        valid_if_i;
  logic        stall_if_o;
  logic [31:0] pc_id_o;
  logic [31:0] instr_id_o;
  logic        is_compressed_id_o;
  logic        valid_id_o;
  logic        ready_id_i;
  logic        flush_i;
  logic [31:0] bubble_cnt_o;

  modport master (
    output pc_if_i, instr_if_i, valid_if_i, ready_id_i, flush_i,
    input  stall_if_o, pc_id_o, instr_id_o, is_compressed_id_o, valid_id_o, bubble_cnt_o
  );

  modport slave (
    input  pc_if_i, instr_if_i, valid_if_i, ready_id_i, flush_i,
    output stall_if_o, pc_id_o, instr_id_o, is_compressed_id_o, valid_id_o, bubble_cnt_o
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID skid FIFO with flush; outputs depend only on registered state.
// Optional decode-starvation counter enabled by macro IF_ID_BUBBLE_CNT_EN.
module if_id_buffer (
  input  logic           clk_i,
  input  logic           rst_n_i,
  if_id_buffer_if.slave  bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q    [2];
  logic [31:0] instr_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign push  = bus.valid_if_i & ~full & ~bus.flush_i;
  assign pop   = ~empty & bus.ready_id_i & ~bus.flush_i;

  // Storage needs no reset: it is never visible while count_q is zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= bus.pc_if_i;
      instr_q[wr_ptr_q] <= bus.instr_if_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (bus.flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
    end
  end

  assign bus.stall_if_o         = full;
  assign bus.valid_id_o         = ~empty;
  assign bus.pc_id_o            = empty ? 32'h0 : pc_q[rd_ptr_q];
  assign bus.instr_id_o         = empty ? NOP   : instr_q[rd_ptr_q];
  assign bus.is_compressed_id_o = (bus.instr_id_o[1:0] != 2'b11);

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= 32'h0;
    end else if (bus.ready_id_i && empty && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_q;
`else
  assign bus.bubble_cnt_o = 32'h0;
`endif

endmodule
